// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
package ifetch_pkg;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } ifq_state_e;

    localparam int unsigned INSTR_BYTES = 4;
    localparam logic [31:0] NOP         = 32'h0000_0013;

endpackage

// File: rtl/ifq_fifo.sv
// Synchronous FIFO with flush and occupancy count; reads as zero when empty.
module ifq_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             wdata_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             rdata_o,
    output logic [$clog2(DEPTH):0]       count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_do_push;
    logic w_do_pop;

    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_do_push = push_i && !w_full && !flush_i;
    assign w_do_pop  = pop_i && !w_empty && !flush_i;

    // Storage needs no reset: the empty mask below hides stale contents.
    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    assign rdata_o = w_empty ? '0 : r_mem[r_rptr];
    assign count_o = r_count;

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push_i && !flush_i && w_full))
        else $error("ifq_fifo: push while full");

endmodule

// File: rtl/ifetch_queue.sv
// Fetch stage: sequential PC, imem request issue, and instruction buffer toward decode.
// Define IFQ_BYPASS_EN to forward a response straight to decode when the buffer is empty.
module ifetch_queue
    import ifetch_pkg::*;
#(
    parameter int unsigned            DATA_WIDTH = 32,
    parameter int unsigned            DEPTH      = 4,
    parameter logic [DATA_WIDTH-1:0]  RESET_PC   = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  halt_i,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] redirect_pc_i,
    output logic                  imem_req_o,
    output logic [DATA_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_ready_i,
    input  logic                  imem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [DATA_WIDTH-1:0] pc_o
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned ENTRY_W = 2 * DATA_WIDTH;

    ifq_state_e            r_state;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [CNT_W-1:0]      r_outstanding;
    logic [CNT_W-1:0]      r_discard;

    logic                  w_redirect;
    logic                  w_credit;
    logic                  w_issue;
    logic                  w_rsp_keep;
    logic                  w_bypass;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_fifo_valid;
    logic [CNT_W-1:0]      w_count;
    logic [CNT_W-1:0]      w_side_count;
    logic [CNT_W-1:0]      w_outstanding_nxt;
    logic [DATA_WIDTH-1:0] w_rsp_pc;
    logic [ENTRY_W-1:0]    w_head;
    logic                  w_unused_pc_lsbs;

    // Redirects during BOOT are ignored; the fetch address is always word aligned.
    assign w_redirect       = redirect_i && (r_state != BOOT);
    assign w_unused_pc_lsbs = ^redirect_pc_i[1:0];

    // Credit covers buffered entries plus every in-flight request, stale or not.
    assign w_credit   = ((CNT_W + 1)'(w_count) + (CNT_W + 1)'(r_outstanding)) < (CNT_W + 1)'(DEPTH);
    assign imem_req_o  = (r_state == FETCH) && !redirect_i && w_credit;
    assign imem_addr_o = r_pc;
    assign w_issue     = imem_req_o && imem_ready_i;

    assign w_rsp_keep        = imem_rvalid_i && (r_discard == '0) && !w_redirect;
    assign w_outstanding_nxt = r_outstanding + CNT_W'(w_issue) - CNT_W'(imem_rvalid_i);
    assign w_fifo_valid      = (w_count != '0);

`ifdef IFQ_BYPASS_EN
    assign w_bypass = w_rsp_keep && !w_fifo_valid && ready_i;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_push = w_rsp_keep && !w_bypass;
    assign w_pop  = w_fifo_valid && ready_i && !w_redirect;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= BOOT;
            r_pc          <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            case (r_state)
                BOOT:    r_state <= FETCH;
                FETCH:   if (!w_redirect && halt_i) r_state <= HALTED;
                HALTED:  if (w_redirect || !halt_i) r_state <= FETCH;
                default: r_state <= BOOT;
            endcase

            if (w_redirect) begin
                r_pc <= {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};
            end else if (w_issue) begin
                r_pc <= r_pc + DATA_WIDTH'(INSTR_BYTES);
            end

            r_outstanding <= w_outstanding_nxt;

            // Everything still in flight after a redirect belongs to the old path.
            if (w_redirect) begin
                r_discard <= w_outstanding_nxt;
            end else if (imem_rvalid_i && (r_discard != '0)) begin
                r_discard <= r_discard - CNT_W'(1);
            end
        end
    end

    ifq_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (DEPTH)
    ) u_pc_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (w_redirect),
        .push_i  (w_issue),
        .wdata_i (r_pc),
        .pop_i   (w_rsp_keep),
        .rdata_o (w_rsp_pc),
        .count_o (w_side_count)
    );

    ifq_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_instr_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (w_redirect),
        .push_i  (w_push),
        .wdata_i ({imem_rdata_i, w_rsp_pc}),
        .pop_i   (w_pop),
        .rdata_o (w_head),
        .count_o (w_count)
    );

    assign valid_o = w_fifo_valid || w_bypass;
    assign instr_o = w_bypass ? imem_rdata_i : w_head[ENTRY_W-1:DATA_WIDTH];
    assign pc_o    = w_bypass ? w_rsp_pc     : w_head[DATA_WIDTH-1:0];

    a_rsp_has_pc: assert property (@(posedge clk_i) disable iff (!rst_ni)
        w_rsp_keep |-> (w_side_count != '0))
        else $error("ifetch_queue: response with no issued PC");

    a_rsp_expected: assert property (@(posedge clk_i) disable iff (!rst_ni)
        imem_rvalid_i |-> (r_outstanding != '0))
        else $error("ifetch_queue: response with nothing outstanding");

endmodule

// File: tb/tb_ifetch_queue.sv
// Scoreboard bench for ifetch_queue: imem model with budgeted grants and programmable latency.
module tb_ifetch_queue;

    logic        clk_i         = 1'b0;
    logic        rst_ni;
    logic        halt_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i  = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i  = 32'h0;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;

`ifdef IFQ_BYPASS_EN
    localparam int FIRST_VALID = 2;
`else
    localparam int FIRST_VALID = 3;
`endif

    typedef struct { logic [31:0] addr; int due; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

    req_t pend[$];
    exp_t exp_q[$];

    int cyc = 0;
    int c0 = 0;
    int checks = 0;
    int errors = 0;
    int budget = 0;
    int lat = 1;
    int acc_cnt = 0;
    int first_valid = -1;
    bit seen_first = 1'b0;

    ifetch_queue #(
        .DATA_WIDTH (32),
        .DEPTH      (4),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .halt_i        (halt_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ready_i  (imem_ready_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .instr_o       (instr_o),
        .pc_o          (pc_o)
    );

    always #5 clk_i = ~clk_i;

    // imem: grant while budget lasts, answer in order with instr = ~addr
    always @(posedge clk_i) begin
        #1;
        cyc = cyc + 1;
        imem_ready_i = (budget > 0);
        if (!rst_ni) begin
            pend.delete();
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = 32'h0;
        end else if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = ~pend[0].addr;
            pend.delete(0);
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = 32'h0;
        end
    end

    // Acceptance bookkeeping and scoreboard monitor, sampled mid-cycle
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (imem_req_o && imem_ready_i) begin
                req_t r;
                r.addr = imem_addr_o;
                r.due  = cyc + lat;
                pend.push_back(r);
                budget  = budget - 1;
                acc_cnt = acc_cnt + 1;
            end
            if (valid_o && !seen_first) begin
                seen_first  = 1'b1;
                first_valid = cyc - c0;
            end
            if (valid_o && ready_i) begin
                checks = checks + 1;
                if (exp_q.size() == 0) begin
                    errors = errors + 1;
                    $display("FAIL sb_unexpected: pc_o=%h instr_o=%h delivered, nothing expected", pc_o, instr_o);
                end else begin
                    if (pc_o !== exp_q[0].pc || instr_o !== exp_q[0].instr) begin
                        errors = errors + 1;
                        $display("FAIL sb_entry: got pc=%h instr=%h, want pc=%h instr=%h",
                                 pc_o, instr_o, exp_q[0].pc, exp_q[0].instr);
                    end
                    exp_q.delete(0);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks = checks + 1;
        if (got !== want) begin
            errors = errors + 1;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = ~pc;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic wait_drain(input int max_cycles, input string name);
        for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) begin
            @(negedge clk_i);
        end
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL %s: %0d entries never delivered, next pc %h", name, exp_q.size(), exp_q[0].pc);
            exp_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        rst_ni        = 1'b0;
        halt_i        = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        ready_i       = 1'b1;
        budget        = 4;
        lat           = 1;

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_req",   32'(imem_req_o), 32'h0);
        check("rst_valid", 32'(valid_o),    32'h0);
        check("rst_instr", instr_o,         32'h0);
        check("rst_pc",    pc_o,            32'h0);

        // T1: sequential fetch after reset, 1-cycle imem latency
        push_exp(32'h0); push_exp(32'h4); push_exp(32'h8); push_exp(32'hC);
        tick();
        rst_ni = 1'b1;
        c0     = cyc;
        @(negedge clk_i);
        check("boot_no_req", 32'(imem_req_o), 32'h0);
        wait_drain(40, "t1_drain");
        check("t1_first_valid_cycle", 32'(first_valid), 32'(FIRST_VALID));
        check("t1_next_addr", imem_addr_o, 32'h10);

        // T2: decode stalled, credit limits to DEPTH requests
        tick();
        ready_i = 1'b0;
        budget  = 8;
        a0      = acc_cnt;
        repeat (12) @(negedge clk_i);
        check("t2_accepts",   32'(acc_cnt - a0), 32'd4);
        check("t2_req_block", 32'(imem_req_o),   32'h0);
        check("t2_head_pc",   pc_o,              32'h10);
        for (int i = 0; i < 8; i++) push_exp(32'h10 + 32'(4 * i));
        tick();
        ready_i = 1'b1;
        wait_drain(80, "t2_drain");

        // T3: redirect with two stale requests in flight, latency 3
        tick();
        lat    = 3;
        budget = 2;
        tick();
        tick();
        tick();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h100;
        budget        = 2;
        push_exp(32'h100); push_exp(32'h104);
        tick();
        redirect_i = 1'b0;
        @(negedge clk_i);
        check("t3_req_after_redirect", 32'(imem_req_o), 32'h1);
        check("t3_addr_after_redirect", imem_addr_o,    32'h100);
        wait_drain(60, "t3_drain");

        // T4: halt, then redirect+halt together with a misaligned target
        lat = 1;
        tick();
        halt_i = 1'b1;
        tick();
        tick();
        @(negedge clk_i);
        check("t4_halted_no_req", 32'(imem_req_o), 32'h0);
        tick();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h203;
        budget        = 1;
        push_exp(32'h200);
        tick();
        redirect_i = 1'b0;
        @(negedge clk_i);
        check("t4_req_in_fetch", 32'(imem_req_o), 32'h1);
        check("t4_aligned_addr", imem_addr_o,     32'h200);
        tick();
        halt_i = 1'b0;
        wait_drain(40, "t4_drain");

        // T5: PC wraps past the top of the address space
        tick();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        budget        = 2;
        push_exp(32'hFFFF_FFFC); push_exp(32'h0);
        tick();
        redirect_i = 1'b0;
        @(negedge clk_i);
        check("t5_top_addr", imem_addr_o, 32'hFFFF_FFFC);
        @(negedge clk_i);
        check("t5_wrap_addr", imem_addr_o, 32'h0);
        wait_drain(40, "t5_drain");

        // T6: redirect flushes entries already buffered
        tick();
        ready_i = 1'b0;
        budget  = 3;
        repeat (8) @(negedge clk_i);
        check("t6_buffered_valid", 32'(valid_o), 32'h1);
        check("t6_buffered_pc",    pc_o,         32'h4);
        check("t6_buffered_instr", instr_o,      32'hFFFF_FFFB);
        tick();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h300;
        budget        = 1;
        push_exp(32'h300);
        tick();
        redirect_i = 1'b0;
        @(negedge clk_i);
        check("t6_flushed_valid", 32'(valid_o), 32'h0);
        tick();
        ready_i = 1'b1;
        wait_drain(40, "t6_drain");

        repeat (5) @(negedge clk_i);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
